// File: rtl/cv32e40x_alu_clmul_iter.sv
// cv32e40x_alu_clmul_iter
// Iterative carry-less multiplier producing CLMUL, CLMULH and CLMULR results.
// STEP multiplier bits are consumed per cycle; operands and the result each
// move through a valid/ready handshake.
// Optional feature macro: CV32E40X_CLMUL_EARLY_EXIT_EN. When defined, the
// iteration stops as soon as the remaining multiplier bits are all zero.
module cv32e40x_alu_clmul_iter #(
  parameter int WIDTH = 32,
  parameter int STEP  = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [1:0]       op_i,
  input  logic [WIDTH-1:0] op_a_i,
  input  logic [WIDTH-1:0] op_b_i,
  input  logic             kill_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] result_o
);

  localparam int NSTEPS = WIDTH / STEP;
  localparam int CNT_W  = $clog2(NSTEPS + 1);

  localparam logic [1:0] OP_CLMULH = 2'b01;
  localparam logic [1:0] OP_CLMULR = 2'b10;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01,
    DONE = 2'b10
  } state_t;

  state_t               state;
  logic                 in_ready_q;
  logic                 out_valid_q;
  logic [2*WIDTH-1:0]   a_q;
  logic [WIDTH-1:0]     b_q;
  logic [2*WIDTH-1:0]   acc_q;
  logic [1:0]           op_q;
  logic [CNT_W-1:0]     cnt_q;

  logic [2*WIDTH-1:0]   acc_step;
  logic [WIDTH-1:0]     b_shift;
  logic                 last_step;

  // One iteration: fold in a << j for every set bit among the low STEP bits of b.
  always_comb begin
    acc_step = acc_q;
    for (int j = 0; j < STEP; j++) begin
      if (b_q[j]) begin
        acc_step = acc_step ^ (a_q << j);
      end
    end
  end

  // Multiplier after this cycle's shift, and whether this is the final step.
  always_comb begin
    b_shift = b_q >> STEP;
`ifdef CV32E40X_CLMUL_EARLY_EXIT_EN
    // Nothing left to accumulate once the remaining multiplier bits are zero.
    last_step = (cnt_q == CNT_W'(1)) || (b_shift == '0);
`else
    last_step = (cnt_q == CNT_W'(1));
`endif
  end

  // Control FSM and datapath registers; kill wins over every handshake.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      acc_q       <= '0;
      op_q        <= '0;
      cnt_q       <= '0;
    end else if (kill_i) begin
      state       <= IDLE;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid_i) begin
            a_q        <= {{WIDTH{1'b0}}, op_a_i};
            b_q        <= op_b_i;
            acc_q      <= '0;
            op_q       <= op_i;
            cnt_q      <= CNT_W'(NSTEPS);
            state      <= BUSY;
            in_ready_q <= 1'b0;
          end
        end
        BUSY: begin
          acc_q <= acc_step;
          a_q   <= a_q << STEP;
          b_q   <= b_shift;
          cnt_q <= cnt_q - CNT_W'(1);
          if (last_step) begin
            state       <= DONE;
            out_valid_q <= 1'b1;
          end
        end
        DONE: begin
          // acc and op stay frozen until the consumer takes the result.
          if (out_ready_i) begin
            state       <= IDLE;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
          end
        end
        default: begin
          state       <= IDLE;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  // Result select from the registered product and operation only.
  always_comb begin
    case (op_q)
      OP_CLMULH: result_o = acc_q[2*WIDTH-1:WIDTH];
      OP_CLMULR: result_o = acc_q[2*WIDTH-2:WIDTH-1];
      default:   result_o = acc_q[WIDTH-1:0];
    endcase
  end

  assign in_ready_o  = in_ready_q;
  assign out_valid_o = out_valid_q;

endmodule
